// File: rtl/naive_bus_arb_pkg.sv
// Shared types and sizing helpers for the naive bus arbiter.
// No logic of its own; imported by the arbiter top and its per-master counter.
package naive_bus_arb_pkg;

  localparam int STARVE_LIMIT_DEF = 15;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_bundle_t;

  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Per-master wait counter: counts cycles a request goes unserved, saturating at LIMIT.
// One cycle to update; clears on handshake or idle, flags starved while requesting at LIMIT.
module arb_starve_cnt
  import naive_bus_arb_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF,
  parameter int W     = cnt_width(LIMIT)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req,
  input  logic         hs,
  output logic [W-1:0] cnt,
  output logic         starved
);

  localparam logic [W-1:0] CNT_MAX = W'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req || hs) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign starved = req && (cnt_q == CNT_MAX);

endmodule

// File: rtl/naive_bus_arbiter.sv
// N-master to one-slave arbiter: static priority with starvation promotion; zero-cycle grant.
// Grant follows s_gnt combinationally; read data returns to the owner one cycle after handshake.
module naive_bus_arbiter
  import naive_bus_arb_pkg::*;
#(
  parameter int N_MASTER     = 3,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_MASTER-1:0]    m_req,
  input  logic [N_MASTER-1:0]    m_we,
  input  logic [N_MASTER*32-1:0] m_addr,
  input  logic [N_MASTER*32-1:0] m_wdata,
  input  logic [N_MASTER*4-1:0]  m_be,
  output logic [N_MASTER-1:0]    m_gnt,
  output logic [N_MASTER*32-1:0] m_rdata,
  output logic [N_MASTER-1:0]    m_rvalid,
  output logic                   s_req,
  output logic                   s_we,
  output logic [31:0]            s_addr,
  output logic [31:0]            s_wdata,
  output logic [3:0]             s_be,
  input  logic                   s_gnt,
  input  logic [31:0]            s_rdata
);

  localparam int CW = cnt_width(STARVE_LIMIT);
  localparam int IW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

  req_bundle_t         bundle [N_MASTER];
  req_bundle_t         sel;
  logic [N_MASTER-1:0] starved;
  logic [CW-1:0]       cnt [N_MASTER];
  logic                win_vld;
  logic [IW-1:0]       win_idx;
  logic                rd_pend_q, rd_pend_d;
  logic [IW-1:0]       rd_owner_q, rd_owner_d;

  for (genvar i = 0; i < N_MASTER; i++) begin : g_master
    assign bundle[i] = '{we:    m_we[i],
                         addr:  m_addr[i*32 +: 32],
                         wdata: m_wdata[i*32 +: 32],
                         be:    m_be[i*4 +: 4]};

    arb_starve_cnt #(
      .LIMIT (STARVE_LIMIT),
      .W     (CW)
    ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (m_req[i]),
      .hs      (m_gnt[i]),
      .cnt     (cnt[i]),
      .starved (starved[i])
    );

    always_ff @(posedge clk) begin
      if (rst_n) assert (!starved[i] || cnt[i] == CNT_MAX);
    end
  end

  // Starved requesters outrank everyone; among equals the lowest index wins.
  always_comb begin
    logic found;
    found   = 1'b0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      if (starved[i] && !found) begin
        found   = 1'b1;
        win_vld = 1'b1;
        win_idx = IW'(i);
      end else if (m_req[i] && !win_vld) begin
        win_vld = 1'b1;
        win_idx = IW'(i);
      end
    end
    if (!rst_n) win_vld = 1'b0;
  end

  always_comb begin
    sel     = win_vld ? bundle[win_idx] : '0;
    s_req   = win_vld;
    s_we    = sel.we;
    s_addr  = sel.addr;
    s_wdata = sel.wdata;
    s_be    = sel.be;

    m_gnt = '0;
    if (win_vld) m_gnt[win_idx] = s_gnt;

    rd_pend_d  = win_vld && s_gnt && !sel.we;
    rd_owner_d = rd_pend_d ? win_idx : rd_owner_q;

    m_rvalid = '0;
    m_rdata  = '0;
    if (rd_pend_q) begin
      m_rvalid[rd_owner_q]           = 1'b1;
      m_rdata[32*rd_owner_q +: 32]   = s_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= '0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

endmodule

// File: tb/tb_naive_bus_arbiter.sv
// Directed bench for naive_bus_arbiter: spec-level model checked every cycle plus literal pins.
module tb_naive_bus_arbiter;

  localparam int N = 3;
  localparam int L = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  m_req, m_we, m_gnt, m_rvalid;
  logic [N*32-1:0] m_addr, m_wdata, m_rdata;
  logic [N*4-1:0]  m_be;
  logic          s_req, s_we, s_gnt;
  logic [31:0]   s_addr, s_wdata;
  logic [3:0]    s_be;
  logic [31:0]   s_rdata = '0;

  naive_bus_arbiter #(.N_MASTER(N), .STARVE_LIMIT(L)) dut (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_be(m_be), .m_gnt(m_gnt), .m_rdata(m_rdata),
    .m_rvalid(m_rvalid), .s_req(s_req), .s_we(s_we), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_be(s_be), .s_gnt(s_gnt), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  // Slave returns address + 0xA0 the cycle after each read handshake.
  always @(posedge clk) begin
    if (s_req && s_gnt && !s_we) s_rdata <= s_addr + 32'hA0;
  end

  int total = 0;
  int bad   = 0;

  logic          lit_g_en, lit_r_en, lit_s_en;
  logic [N-1:0]  lit_gnt, lit_rv;
  logic [95:0]   lit_rdata;
  logic          lit_sreq;
  logic [31:0]   lit_saddr;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Model state: wait cycles per master and the outstanding read.
  int          wt [N];
  bit          pend;
  int          pend_own;
  logic [31:0] pend_addr;

  initial begin
    int          win;
    logic        e_sreq, e_swe;
    logic [31:0] e_saddr, e_swdata;
    logic [3:0]  e_sbe;
    logic [N-1:0] e_gnt, e_rv;
    logic [95:0] e_rdata;
    for (int i = 0; i < N; i++) wt[i] = 0;
    pend = 0; pend_own = 0; pend_addr = '0;
    forever begin
      @(negedge clk);
      win = -1;
      e_sreq = 0; e_swe = 0; e_saddr = '0; e_swdata = '0; e_sbe = '0;
      e_gnt = '0; e_rv = '0; e_rdata = '0;
      if (rst_n) begin
        for (int i = 0; i < N; i++)
          if (win < 0 && m_req[i] && wt[i] == L) win = i;
        for (int i = 0; i < N; i++)
          if (win < 0 && m_req[i]) win = i;
        if (win >= 0) begin
          e_sreq   = 1;
          e_swe    = m_we[win];
          e_saddr  = m_addr[win*32 +: 32];
          e_swdata = m_wdata[win*32 +: 32];
          e_sbe    = m_be[win*4 +: 4];
          e_gnt[win] = s_gnt;
        end
        if (pend) begin
          e_rv[pend_own] = 1;
          e_rdata[pend_own*32 +: 32] = pend_addr + 32'hA0;
        end
      end
      chk("s_req",    96'(s_req),    96'(e_sreq));
      chk("s_we",     96'(s_we),     96'(e_swe));
      chk("s_addr",   96'(s_addr),   96'(e_saddr));
      chk("s_wdata",  96'(s_wdata),  96'(e_swdata));
      chk("s_be",     96'(s_be),     96'(e_sbe));
      chk("m_gnt",    96'(m_gnt),    96'(e_gnt));
      chk("m_rvalid", 96'(m_rvalid), 96'(e_rv));
      chk("m_rdata",  m_rdata,       e_rdata);
      if (lit_g_en) chk("lit_gnt", 96'(m_gnt), 96'(lit_gnt));
      if (lit_r_en) begin
        chk("lit_rvalid", 96'(m_rvalid), 96'(lit_rv));
        chk("lit_rdata",  m_rdata,       lit_rdata);
      end
      if (lit_s_en) begin
        chk("lit_sreq",  96'(s_req),  96'(lit_sreq));
        chk("lit_saddr", 96'(s_addr), 96'(lit_saddr));
      end
      if (!rst_n) begin
        for (int i = 0; i < N; i++) wt[i] = 0;
        pend = 0; pend_own = 0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (m_req[i] && !(win == i && s_gnt)) wt[i] = (wt[i] < L) ? wt[i] + 1 : L;
          else wt[i] = 0;
        end
        pend = (win >= 0) && s_gnt && !m_we[win];
        if (pend) begin
          pend_own  = win;
          pend_addr = m_addr[win*32 +: 32];
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    lit_g_en = 0; lit_r_en = 0; lit_s_en = 0;
  endtask

  task automatic lit_g(input logic [N-1:0] g);
    lit_g_en = 1; lit_gnt = g;
  endtask

  task automatic lit_r(input logic [N-1:0] rv, input logic [95:0] rd);
    lit_r_en = 1; lit_rv = rv; lit_rdata = rd;
  endtask

  task automatic lit_s(input logic rq, input logic [31:0] a);
    lit_s_en = 1; lit_sreq = rq; lit_saddr = a;
  endtask

  task automatic set_m(input int i, input logic rq, input logic we,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    m_req[i] = rq; m_we[i] = we;
    m_addr[i*32 +: 32] = a; m_wdata[i*32 +: 32] = d; m_be[i*4 +: 4] = be;
  endtask

  initial begin
    rst_n = 0; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_be = '0; s_gnt = 0;
    lit_g_en = 0; lit_r_en = 0; lit_s_en = 0;
    lit_gnt = '0; lit_rv = '0; lit_rdata = '0; lit_sreq = 0; lit_saddr = '0;

    // Reset: outputs quiet even with requests and s_gnt asserted.
    lit_g(3'b000); lit_r(3'b000, 96'h0); lit_s(0, 32'h0); step();
    for (int i = 0; i < N; i++) set_m(i, 1, 0, 32'(i), 32'h0, 4'h0);
    s_gnt = 1;
    lit_g(3'b000); lit_r(3'b000, 96'h0); lit_s(0, 32'h0); step();

    // Three simultaneous reads, served in priority order.
    rst_n = 1;
    lit_g(3'b001); lit_r(3'b000, 96'h0); lit_s(1, 32'h0); step();
    m_req[0] = 0; lit_g(3'b010); lit_r(3'b001, {64'h0, 32'hA0}); step();
    m_req[1] = 0; lit_g(3'b100); lit_r(3'b010, {32'h0, 32'hA1, 32'h0}); step();
    m_req[2] = 0; lit_g(3'b000); lit_r(3'b100, {32'hA2, 64'h0}); lit_s(0, 32'h0); step();
    lit_r(3'b000, 96'h0); step();

    // Single write from master 1.
    set_m(1, 1, 1, 32'h0001_0004, 32'hDEAD_BEEF, 4'hF);
    lit_g(3'b010); lit_s(1, 32'h0001_0004); step();
    m_req[1] = 0; lit_r(3'b000, 96'h0); step();

    // Master 0 hogs; master 2 promoted after 15 cycles of waiting.
    set_m(0, 1, 0, 32'h100, 32'h0, 4'h0);
    set_m(2, 1, 0, 32'h200, 32'h0, 4'h0);
    for (int k = 0; k <= 16; k++) begin
      lit_g(k == 15 ? 3'b100 : 3'b001); step();
    end
    m_req = '0; step(); step();

    // Slave stalls 20 cycles; both waiters saturate, master 1 wins first.
    set_m(1, 1, 0, 32'h300, 32'h0, 4'h0);
    set_m(2, 1, 0, 32'h400, 32'h0, 4'h0);
    s_gnt = 0;
    repeat (20) begin
      lit_g(3'b000); lit_s(1, 32'h300); step();
    end
    s_gnt = 1;
    lit_g(3'b010); lit_s(1, 32'h300); step();
    lit_g(3'b100); lit_s(1, 32'h400); lit_r(3'b010, {32'h0, 32'h3A0, 32'h0}); step();
    m_req = '0; lit_r(3'b100, {32'h4A0, 64'h0}); step();
    step();

    // Read handshake then reset before the data edge: nothing delivered.
    set_m(2, 1, 0, 32'h500, 32'h0, 4'h0);
    lit_g(3'b100);
    @(negedge clk);
    #2 rst_n = 0;
    step();
    set_m(0, 1, 0, 32'h600, 32'h0, 4'h0);
    set_m(2, 1, 0, 32'h700, 32'h0, 4'h0);
    lit_g(3'b000); lit_r(3'b000, 96'h0); lit_s(0, 32'h0); step();

    // After release: static priority, counters fresh; drop-and-retry restarts aging.
    rst_n = 1;
    for (int k = 0; k < 10; k++) begin
      lit_g(3'b001);
      if (k == 0) lit_r(3'b000, 96'h0);
      step();
    end
    m_req[2] = 0; lit_g(3'b001); step();
    m_req[2] = 1;
    for (int k = 0; k <= 15; k++) begin
      lit_g(k == 15 ? 3'b100 : 3'b001); step();
    end
    m_req = '0; step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/naive_bus_arbiter.md
NAIVE_BUS_ARBITER -- requirements
Module: naive_bus_arbiter

Interface
REQ-001 SHALL have parameter N_MASTER, default 3, number of requesting masters (index 0 = highest static priority).
REQ-002 SHALL have parameter STARVE_LIMIT, default 15, wait cycles after which a requester is promoted; legal range 1..255.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port m_req  input  N_MASTER  per-master request.
REQ-006 SHALL have port m_we  input  N_MASTER  per-master write (1) / read (0).
REQ-007 SHALL have port m_addr  input  N_MASTER x 32  per-master byte address.
REQ-008 SHALL have port m_wdata  input  N_MASTER x 32  per-master write data.
REQ-009 SHALL have port m_be  input  N_MASTER x 4  per-master write byte enables.
REQ-010 SHALL have port m_gnt  output  N_MASTER  per-master grant (handshake = req & gnt).
REQ-011 SHALL have port m_rdata  output  N_MASTER x 32  per-master read data.
REQ-012 SHALL have port m_rvalid  output  N_MASTER  read data valid, one cycle.
REQ-013 SHALL have ports s_req/s_we/s_addr/s_wdata/s_be  output  1/1/32/32/4  shared downstream request.
REQ-014 SHALL have port s_gnt  input  1  downstream grant.
REQ-015 SHALL have port s_rdata  input  32  downstream read data, valid the cycle after a read handshake.

Function
REQ-016 SHALL select at most one winner per cycle, combinationally from m_req and wait counters.
REQ-017 SHALL pick the lowest-index master whose counter equals STARVE_LIMIT; if none, the lowest-index requesting master.
REQ-018 SHALL drive s_req=1 and the winner's we/addr/wdata/be when a winner exists; otherwise s_req=0 and the other s_* outputs 0.
REQ-019 SHALL drive m_gnt[winner]=s_gnt and m_gnt of all other masters 0; no combinational path from s_gnt to s_req.
REQ-020 SHALL keep one wait counter per master, width clog2(STARVE_LIMIT+1).
REQ-021 Counter SHALL increment (saturating at STARVE_LIMIT) in cycles where m_req=1 and no handshake for that master.
REQ-022 Counter SHALL clear to 0 on that master's handshake or in any cycle its m_req=0.
REQ-023 On a read handshake SHALL register rd_owner=winner and rd_pend=1; otherwise rd_pend=0 next cycle.
REQ-024 When rd_pend=1 SHALL drive m_rvalid[rd_owner]=1 and m_rdata[rd_owner]=s_rdata; all other m_rvalid=0, m_rdata=0.
REQ-025 Back-to-back read handshakes from different masters SHALL each return data to the correct owner on consecutive cycles.
REQ-026 Write handshakes SHALL produce no m_rvalid.
REQ-027 s_gnt=0 for any number of cycles SHALL hold the winner's request stable (inputs permitting) and age all waiting counters.
REQ-028 Single requester SHALL see zero arbitration latency: m_gnt in the same cycle as s_gnt.

Reset
REQ-029 While rst_n=0: all counters 0, rd_pend 0, rd_owner 0, m_rvalid 0, m_rdata 0, s_req 0, m_gnt 0.
REQ-030 Reset asserted mid-read SHALL drop the pending m_rvalid; no data delivered after reset release.
REQ-031 First arbitration SHALL occur in the first rising edge cycle after rst_n deasserts, static priority only.

Structure
REQ-032 Package naive_bus_arb_pkg SHALL hold STARVE_LIMIT default, counter-width function, and the request bundle struct (we, addr, wdata, be).
REQ-033 Per-master counter SHALL be sub-module arb_starve_cnt (inputs req, hs; output cnt, starved), instantiated N_MASTER times via generate.
REQ-034 Winner select SHALL be a single always_comb priority loop; no latches.

Verification
REQ-035 Masters 0,1,2 read simultaneously, s_gnt=1 every cycle -> grants in order 0,1,2 on three cycles; m_rvalid to 0,1,2 next cycles with s_rdata 0xA0,0xA1,0xA2.
REQ-036 Master 0 requests continuously, master 2 requests continuously, STARVE_LIMIT=15 -> master 2 granted on cycle 16 of waiting, then master 0 resumes.
REQ-037 s_gnt held 0 for 20 cycles with masters 1,2 requesting -> no m_gnt, s_addr = master 1 address, both counters saturate at 15; on s_gnt=1 master 1 (lowest starving) wins.
REQ-038 Master 1 write addr 0x00010004 data 0xDEADBEEF be 0xF -> s_* match, m_gnt[1]=1, no m_rvalid next cycle.
REQ-039 Read handshake by master 2 then rst_n=0 before next edge -> m_rvalid stays 0; after release counters read 0.
REQ-040 Master 2 waits 10 cycles, drops req 1 cycle, re-requests -> counter restarts from 0, promotion delayed to 16 cycles after re-request.
